// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_arb_pkg;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_t;

    localparam int FIFO_DEPTH = 16;
    localparam int DWIDTH_DEF = 8;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake bundle plus FIFO write-port signals for the arbiter.
// Latency: n/a (wires only).
// Backpressure: req_ready per producer, driven by the arbiter from fifo_full.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DWIDTH  = DWIDTH_DEF
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DWIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr;
    logic [DWIDTH-1:0]         fifo_din;
    logic [IW-1:0]             grant_id;
    logic                      busy;

    // Arbiter side.
    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr, fifo_din, grant_id, busy
    );

    // Producers/FIFO side.
    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr, fifo_din, grant_id, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above base, wrapping modulo N.
// Latency: combinational.
// Backpressure: none.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW:0] cand;

    // Scan from the farthest offset down so the nearest offset to base wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, base} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (req[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the shared FIFO write port; optional stall counter under FIFO_ARB_STALL_CNT_EN.
// Latency: 1 cycle request-to-grant; beats reach fifo_wr/fifo_din combinationally.
// Backpressure: fifo_full drops the grantee's ready and freezes the burst; one write-free cycle between bursts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_wr_arbiter_if.master  bus
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t        state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     grant_q;
    logic [IW-1:0]     rr_next;
    logic [IW-1:0]     pick_idx;
    logic              pick_found;
    logic [BW-1:0]     beat_cnt;
    logic              in_burst;
    logic              gnt_valid;
    logic [DWIDTH-1:0] gnt_data;
    logic              xfer;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (bus.req_valid),
        .base  (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign in_burst  = (state == BURST);
    assign gnt_valid = bus.req_valid[grant_q];
    assign gnt_data  = bus.req_data[int'(grant_q)*DWIDTH +: DWIDTH];
    // rst_n gating keeps the reset cycle write-free even if a burst was in flight.
    assign xfer      = in_burst && gnt_valid && !bus.fifo_full && rst_n;
    assign rr_next   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);

    assign bus.fifo_wr  = xfer;
    assign bus.fifo_din = xfer ? gnt_data : '0;
    assign bus.grant_id = grant_q;
    assign bus.busy     = in_burst;

    // Only the grantee sees ready, and only while the FIFO has room.
    always_comb begin
        bus.req_ready = '0;
        if (in_burst && rst_n) begin
            bus.req_ready[grant_q] = !bus.fifo_full;
        end
    end

    // Arbitration FSM: pick in IDLE, count beats in BURST, advance pointer on exit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_q  <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_q  <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (!gnt_valid) begin
                        state  <= IDLE;
                        rr_ptr <= rr_next;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (beat_cnt == BW'(MAX_BURST - 1)) begin
                            state  <= IDLE;
                            rr_ptr <= rr_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    // Saturating count of cycles the grantee was held off by a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_burst && gnt_valid && bus.fifo_full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: round-robin order, burst length, idle gap, full stall, early drop, reset.
// Latency: checks combinational outputs 2 time units after each rising edge.
// Backpressure: fifo_full driven directly by the stimulus.
module tb_fifo_wr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] fq[$];

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DWIDTH(8)) bus ();

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    fifo_wr_arbiter #(.NUM_REQ(4), .DWIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef FIFO_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference FIFO contents: every strobed beat lands here.
    always @(posedge clk) begin
        if (bus.fifo_wr) fq.push_back(bus.fifo_din);
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        bus.req_data[i*8 +: 8] = d;
    endtask

    // Check one cycle's outputs, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic eb, input logic [1:0] eg,
                       input logic ew, input logic [7:0] ed, input logic [3:0] er);
        #1;
        chk({tag, "_busy"}, 32'(bus.busy), 32'(eb));
        chk({tag, "_wr"},   32'(bus.fifo_wr), 32'(ew));
        chk({tag, "_din"},  32'(bus.fifo_din), 32'(ed));
        chk({tag, "_rdy"},  32'(bus.req_ready), 32'(er));
        if (eb) chk({tag, "_gid"}, 32'(bus.grant_id), 32'(eg));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0] order [5];
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rdy",  32'(bus.req_ready), 0);
        chk("rst_wr",   32'(bus.fifo_wr), 0);
        chk("rst_din",  32'(bus.fifo_din), 0);
        chk("rst_gid",  32'(bus.grant_id), 0);
`ifdef FIFO_ARB_STALL_CNT_EN
        chk("rst_stall", 32'(stall_cnt), 0);
`endif
        rst_n = 1'b1;

        // Single producer 0, valid held: 4 beats, one idle cycle, 4 beats
        bus.req_valid = 4'b0001;
        set_data(0, 8'h10);
        cyc("t1_idle0", 0, 0, 0, 8'h00, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            set_data(0, 8'(8'h10 + k));
            cyc("t1_beat", 1, 0, 1, 8'(8'h10 + k), 4'b0001);
        end
        set_data(0, 8'h14);
        cyc("t1_gap", 0, 0, 0, 8'h00, 4'b0000);
        for (int k = 4; k < 8; k++) begin
            set_data(0, 8'(8'h10 + k));
            cyc("t1_beat2", 1, 0, 1, 8'(8'h10 + k), 4'b0001);
        end
        bus.req_valid = 4'b0000;
        cyc("t1_end", 0, 0, 0, 8'h00, 4'b0000);
        chk("t1_fifo_cnt", 32'(fq.size()), 8);
        for (int k = 0; k < 8; k++) begin
            chk("t1_fifo_dat", (fq.size() > k) ? 32'(fq[k]) : 32'hDEAD, 32'(8'h10 + k));
        end

        // Reset pulse so the pointer restarts at 0
        rst_n = 1'b0;
        #1;
        chk("t2_rst_wr", 32'(bus.fifo_wr), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fq.delete();

        // All four producers valid: grants 0,1,2,3,0 with 4-beat bursts and one idle gap
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'hA0 + i));
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        for (int b = 0; b < 5; b++) begin
            cyc("t2_idle", 0, 0, 0, 8'h00, 4'b0000);
            for (int k = 0; k < 4; k++) begin
                cyc("t2_beat", 1, order[b], 1, 8'(8'hA0 + order[b]), 4'(4'b0001 << order[b]));
            end
        end
        bus.req_valid = 4'b0000;
        cyc("t2_end", 0, 0, 0, 8'h00, 4'b0000);
        chk("t2_fifo_cnt", 32'(fq.size()), 20);

        // Producer 2 alone, FIFO full for 3 cycles after beat 2
        bus.req_valid = 4'b0100;
        set_data(2, 8'hC0);
        cyc("t3_idle", 0, 0, 0, 8'h00, 4'b0000);
        cyc("t3_b1", 1, 2, 1, 8'hC0, 4'b0100);
        set_data(2, 8'hC1);
        cyc("t3_b2", 1, 2, 1, 8'hC1, 4'b0100);
        set_data(2, 8'hC2);
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) cyc("t3_stall", 1, 2, 0, 8'h00, 4'b0000);
        bus.fifo_full = 1'b0;
        cyc("t3_b3", 1, 2, 1, 8'hC2, 4'b0100);
        set_data(2, 8'hC3);
        cyc("t3_b4", 1, 2, 1, 8'hC3, 4'b0100);
        bus.req_valid = 4'b0000;
        cyc("t3_end", 0, 0, 0, 8'h00, 4'b0000);
`ifdef FIFO_ARB_STALL_CNT_EN
        chk("t3_stall_cnt", 32'(stall_cnt), 3);
`endif

        // Grantee 3 drops valid after 2 beats; pointer moves to 0 so producer 1 beats 3
        bus.req_valid = 4'b1010;
        set_data(3, 8'hD3);
        set_data(1, 8'hB1);
        cyc("t4_idle", 0, 0, 0, 8'h00, 4'b0000);
        cyc("t4_b1", 1, 3, 1, 8'hD3, 4'b1000);
        cyc("t4_b2", 1, 3, 1, 8'hD3, 4'b1000);
        bus.req_valid = 4'b0010;
        cyc("t4_drop", 1, 3, 0, 8'h00, 4'b1000);
        bus.req_valid = 4'b1010;
        cyc("t4_gap", 0, 0, 0, 8'h00, 4'b0000);
        cyc("t4_next", 1, 1, 1, 8'hB1, 4'b0010);
        bus.req_valid = 4'b0000;
        cyc("t4_drop2", 1, 1, 0, 8'h00, 4'b0010);
        cyc("t4_end", 0, 0, 0, 8'h00, 4'b0000);

        // Reset during beat 2: one beat kept, reset cycle write-free, pointer back to 0
        fq.delete();
        bus.req_valid = 4'b0010;
        set_data(1, 8'hE0);
        cyc("t5_idle", 0, 0, 0, 8'h00, 4'b0000);
        cyc("t5_b1", 1, 1, 1, 8'hE0, 4'b0010);
        set_data(1, 8'hE1);
        rst_n = 1'b0;
        #1;
        chk("t5_rstcyc_wr",  32'(bus.fifo_wr), 0);
        chk("t5_rstcyc_rdy", 32'(bus.req_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req_valid = 4'b1010;
        set_data(1, 8'hE2);
        #1;
        chk("t5_post_gid", 32'(bus.grant_id), 0);
        chk("t5_fifo_cnt", 32'(fq.size()), 1);
        chk("t5_fifo_dat", (fq.size() > 0) ? 32'(fq[0]) : 32'hDEAD, 32'hE0);
        cyc("t5_post", 0, 0, 0, 8'h00, 4'b0000);
        cyc("t5_regrant", 1, 1, 1, 8'hE2, 4'b0010);
        bus.req_valid = 4'b0000;
        cyc("t5_drop", 1, 1, 0, 8'h00, 4'b0010);
        cyc("t5_end", 0, 0, 0, 8'h00, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
